// File: rtl/down_timer_load_if.sv
// Control and status bundle for the loadable down-timer.
// The master side drives the period and control, and the slave side returns the count and status.
interface down_timer_load_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             LOAD_n;
  logic             START;
  logic             STOP;
  logic             ENP;
  logic             ENT;
  logic             AUTO_RELOAD;
  logic [WIDTH-1:0] Q;
  logic             BO;
  logic             DONE;
  logic             BUSY;

  modport master (
    output D, LOAD_n, START, STOP, ENP, ENT, AUTO_RELOAD,
    input  Q, BO, DONE, BUSY
  );

  modport slave (
    input  D, LOAD_n, START, STOP, ENP, ENT, AUTO_RELOAD,
    output Q, BO, DONE, BUSY
  );
endinterface

// File: rtl/down_timer_load.sv
// Loadable down-counter/timer with one-shot or auto-reload expiry.
// It provides a one-cycle DONE pulse and a borrow output for cascading.
module down_timer_load #(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              CLR_n,
  down_timer_load_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             done_r;
  logic             busy_r;

  logic             qual_en_s;
  logic             at_zero_s;
  logic             at_one_s;
  logic             start_ok_s;

  // Decode the enable qualification and count boundaries used by the FSM and borrow.
  always_comb begin
    qual_en_s  = bus.ENP && bus.ENT;
    at_zero_s  = 1'b0;
    at_one_s   = 1'b0;
    start_ok_s = 1'b0;
    if (count_r == {WIDTH{1'b0}}) begin
      at_zero_s = 1'b1;
    end else begin
      at_zero_s = 1'b0;
    end
    if (count_r == WIDTH'(1)) begin
      at_one_s = 1'b1;
    end else begin
      at_one_s = 1'b0;
    end
    if (bus.START && !bus.STOP && !at_zero_s) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
  end

  // Timer FSM: load > stop > expiry/decrement > start, with registered DONE and BUSY.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_r  <= ST_IDLE;
      count_r  <= {WIDTH{1'b0}};
      reload_r <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!bus.LOAD_n) begin
        count_r  <= bus.D;
        reload_r <= bus.D;
        state_r  <= ST_IDLE;
        busy_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start_ok_s) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
          ST_RUN: begin
            if (bus.STOP) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (at_zero_s) begin
              // Unreachable in normal operation; fall back to IDLE rather than wrap.
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (qual_en_s) begin
              if (at_one_s) begin
                done_r <= 1'b1;
                if (bus.AUTO_RELOAD) begin
                  count_r <= reload_r;
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
                end else begin
                  count_r <= {WIDTH{1'b0}};
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end else begin
                count_r <= count_r - WIDTH'(1);
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Q    = count_r;
  assign bus.BO   = bus.ENT && at_zero_s;
  assign bus.DONE = done_r;
  assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_down_timer_load.sv
// Bench for down_timer_load: directed scenarios followed by random stimulus.
// All outputs are checked against a behavioural timer model.
module tb_down_timer_load;
  localparam int W = 8;

  logic CLK;
  logic CLR_n;
  int   n_cmp;
  int   n_err;

  // Reference model state
  int m_cnt;
  int m_rel;
  bit m_run;
  bit m_done;

  down_timer_load_if #(.WIDTH(W)) bus ();

  down_timer_load #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_q"},    32'(bus.Q),    32'(m_cnt));
    chk({tag, "_done"}, 32'(bus.DONE), 32'(m_done));
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'(m_run));
    chk({tag, "_bo"},   32'(bus.BO),   32'(bus.ENT && (m_cnt == 0)));
  endtask

  // Applies one clock of stimulus; the model follows the timer's rules one edge at a time.
  task automatic cyc(input string tag, input bit ld_n, input int d, input bit st,
                     input bit sp, input bit ep, input bit et, input bit ar);
    bus.LOAD_n      = ld_n;
    bus.D           = W'(d);
    bus.START       = st;
    bus.STOP        = sp;
    bus.ENP         = ep;
    bus.ENT         = et;
    bus.AUTO_RELOAD = ar;
    @(posedge CLK);
    m_done = 1'b0;
    if (!ld_n) begin
      m_cnt = d % (1 << W);
      m_rel = m_cnt;
      m_run = 1'b0;
    end else if (!m_run) begin
      if (st && !sp && m_cnt > 0) m_run = 1'b1;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (ep && et) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        if (ar) m_cnt = m_rel;
        else m_run = 1'b0;
      end
    end
    @(negedge CLK);
    check_outputs(tag);
  endtask

  // Pulses CLR_n between edges and checks that the outputs clear immediately.
  task automatic pulse_reset(input string tag);
    #2;
    CLR_n = 1'b0;
    #1;
    m_cnt  = 0;
    m_rel  = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    chk({tag, "_q"},    32'(bus.Q),    32'd0);
    chk({tag, "_done"}, 32'(bus.DONE), 32'd0);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_bo"},   32'(bus.BO),   32'(bus.ENT));
    #1;
    CLR_n = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.LOAD_n      = 1'b1;
    bus.D           = '0;
    bus.START       = 1'b0;
    bus.STOP        = 1'b0;
    bus.ENP         = 1'b0;
    bus.ENT         = 1'b1;
    bus.AUTO_RELOAD = 1'b0;
    CLR_n           = 1'b0;
    m_cnt = 0; m_rel = 0; m_run = 1'b0; m_done = 1'b0;
    #12;
    check_outputs("reset");
    CLR_n = 1'b1;
    @(negedge CLK);

    // 1: one-shot from 5
    cyc("t1_load", 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t1_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc("t1_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_final_q", 32'(bus.Q), 32'd0);
    chk("t1_final_busy", 32'(bus.BUSY), 32'd0);

    // 2: auto-reload period 3
    cyc("t2_load", 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t2_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc("t2_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t2_busy", 32'(bus.BUSY), 32'd1);

    // 3: pause and resume, then ENP low holds
    cyc("t3_load", 1'b0, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t3_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t3_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t3_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t3_stop", 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_held_q", 32'(bus.Q), 32'd6);
    cyc("t3_resume", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t3_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_resumed_q", 32'(bus.Q), 32'd5);
    for (int i = 0; i < 3; i++) cyc("t3_enp0", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_enp0_busy", 32'(bus.BUSY), 32'd1);

    // 4: zero period cannot start; BO follows ENT
    cyc("t4_load", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t4_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_bo_ent1", 32'(bus.BO), 32'd1);
    cyc("t4_ent0", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_bo_ent0", 32'(bus.BO), 32'd0);

    // 5: load wins over coincident expiry
    cyc("t5_load", 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t5_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t5_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t5_reload", 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_q", 32'(bus.Q), 32'd9);
    chk("t5_done", 32'(bus.DONE), 32'd0);

    // 6: async reset mid-run, then START ignored
    cyc("t6_load", 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t6_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t6_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t6_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_reset("t6_rst");
    cyc("t6_start_ign", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // DONE must drop asynchronously when reset lands during a pulse
    cyc("t7_load", 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t7_start", 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t7_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t7_run", 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t7_done_pre", 32'(bus.DONE), 32'd1);
    pulse_reset("t7_rst");

    // Random phase
    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5)),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/down_timer_load.md
Name: down_timer_load

Overview:
- Loadable, presettable down-counter/timer; the decrementing counterpart to the team's up-counter with ripple-carry output.
- Loads a period, counts down on qualified enable cycles, and flags expiry with a one-cycle DONE pulse.
- Supports one-shot and auto-reload modes.
- Exposes a borrow output for cascading wider timers, mirroring the RCO/ENT chaining used on the up-count side.

Parameters:
WIDTH, 8, counter and period width in bits (>=2)

Ports:
CLK  input  1  clock, all state changes on rising edge
CLR_n  input  1  asynchronous active-low reset
D  input  WIDTH  parallel period/preset value
LOAD_n  input  1  synchronous active-low load of D into count and reload register
START  input  1  level-sampled request to begin or resume counting
STOP  input  1  level-sampled request to pause counting
ENP  input  1  count enable, parallel
ENT  input  1  count enable, trickle; also gates BO
AUTO_RELOAD  input  1  1 = periodic mode, 0 = one-shot
Q  output  WIDTH  current count
BO  output  1  borrow out, combinational: ENT && (Q == 0)
DONE  output  1  registered one-cycle expiry pulse
BUSY  output  1  registered, 1 while state == RUN

Behaviour:
- Reset (CLR_n low, asynchronous, immediate):
  - count = 0, reload_reg = 0, state = IDLE.
  - Q = 0, DONE = 0, BUSY = 0.
  - BO = ENT (count is 0).
- Internal state:
  - count[WIDTH-1:0] and reload_reg[WIDTH-1:0].
  - FSM states: IDLE and RUN.
- Priority per rising edge: reset > LOAD > STOP > expiry/decrement > START.
- DONE defaults to 0 on every edge unless set by an expiry.
- LOAD_n == 0, any state:
  - count <= D, reload_reg <= D, state <= IDLE, DONE <= 0.
  - START, STOP and enables are ignored that cycle.
- IDLE:
  - count holds; enables have no effect.
  - START=1, STOP=0, count != 0 -> RUN; BUSY=1 next cycle. The first decrement can occur on the following edge.
  - START with count == 0 -> ignored, remain IDLE, no DONE.
  - START and STOP together -> remain IDLE.
- RUN, STOP=1:
  - -> IDLE; count holds its current value (pause).
  - A later START resumes from the held count.
- RUN, ENP && ENT, count > 1: count <= count - 1.
- RUN, ENP && ENT, count == 1 (expiry):
  - DONE <= 1 for exactly one cycle.
  - AUTO_RELOAD=1: count <= reload_reg, stay RUN.
  - AUTO_RELOAD=0: count <= 0, state <= IDLE, BUSY=0 next cycle.
- RUN, enables not both high: count holds, no DONE.
- Timing consequences:
  - Auto-reload period = reload_reg qualified enable cycles.
  - reload_reg == 1 with enables held high gives DONE on every cycle.
- Arithmetic and cascading:
  - Count never underflows; 0 is reachable only via one-shot expiry, LOAD of 0, or reset.
  - No modular wrap.
  - BO is purely combinational on ENT and count. It is independent of state, so downstream stages can chain ENT from BO.
- AUTO_RELOAD is sampled only on the expiry edge; changing it mid-run is legal.
- Reset mid-RUN aborts immediately: DONE and BUSY fall asynchronously, and no pulse is emitted.
- LOAD mid-RUN:
  - Aborts to IDLE with the new value.
  - If it coincides with an expiry edge, LOAD wins and no DONE is emitted.

Test Plan:
1. Reset then LOAD D=5, START, ENP=ENT=1, AUTO_RELOAD=0 -> Q: 5,4,3,2,1,0 on successive edges after RUN entry; DONE high only on the cycle Q becomes 0; BUSY falls the same edge; Q stays 0.
2. LOAD D=3, AUTO_RELOAD=1, START, enables high for 10 cycles -> Q sequence 3,2,1,3,2,1,3...; DONE pulses every 3rd cycle; BUSY stays 1.
3. LOAD D=8, START, STOP asserted at Q=6 for 4 cycles, then START -> Q holds 6, BUSY=0 while paused; resumes 5,4... ; ENP=0 mid-run also holds Q with BUSY=1.
4. LOAD D=0 then START -> stays IDLE, no DONE; BO=1 with ENT=1, BO=0 with ENT=0.
5. LOAD D=2, RUN, assert LOAD_n=0 with D=9 on the cycle Q=1 and enables high -> Q=9, IDLE, DONE stays 0.
6. LOAD D=4, RUN to Q=2, pulse CLR_n low between clock edges -> Q=0, BUSY=0, DONE=0 immediately; after release, START is ignored until the next LOAD.
